// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and flush sequencer for the five-stage core.
// Compares the ID-stage sources against the EX, MEM and WB destinations,
// holds fetch and bubbles ID/EX for as many cycles as the dependency needs,
// and sequences the squash that follows a taken branch from EX/MEM.
//
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   - datapath forwards from EX/MEM/WB; only a load-use on the EX
//               stage stalls, for a single cycle (STALL stays in the FSM but
//               cannot be reached).
//   undefined - no forwarding; EX/MEM/WB matches stall 3/2/1 cycles.
//
// hazard, id_bubble and flush are combinational by design: fetch must be held
// in the same cycle the dependent instruction sits in ID. They are forced low
// while reset is asserted.

module hazard_ctrl #(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_regwrite,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic             ex_memread,
  input  logic             branch_cond,
  output logic             hazard,
  output logic             id_bubble,
  output logic             flush,
  output logic [1:0]       stall_count
);

  localparam int unsigned NEED_W = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [NEED_W-1:0] NEED_NONE = NEED_W'(0);
  localparam logic [NEED_W-1:0] NEED_WB   = NEED_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(3);

  logic [1:0]        state_q, state_d;
  logic [NEED_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic              ex_match_c;
  logic [NEED_W-1:0] need_c;
  logic              hazard_c;
  logic              flush_c;

  // True when a writing stage's destination feeds a source ID actually reads.
  function automatic logic src_match(input logic             regwrite,
                                     input logic [REG_W-1:0] rd);
    logic hit;
    hit = (id_use_rs1 && (id_rs1 == rd)) || (id_use_rs2 && (id_rs2 == rd));
    return id_valid && regwrite && (rd != REG_W'(0)) && hit;
  endfunction

  // EX-stage dependency is needed by both build variants.
  always_comb begin
    ex_match_c = src_match(ex_regwrite, ex_rd);
  end

`ifdef HAZARD_FORWARD_EN
  logic unused_fwd;

  // With forwarding only a load result in EX cannot reach ID in time.
  always_comb begin
    need_c = NEED_NONE;
    if (ex_match_c && ex_memread) begin
      need_c = NEED_WB;
    end
  end

  // MEM/WB destinations are covered by forwarding paths.
  always_comb begin
    unused_fwd = ^{mem_rd, wb_rd, mem_regwrite, wb_regwrite};
  end
`else
  localparam logic [NEED_W-1:0] NEED_MEM = NEED_W'(2);
  localparam logic [NEED_W-1:0] NEED_EX  = NEED_W'(3);

  logic mem_match_c;
  logic wb_match_c;
  logic unused_nofwd;

  // Closest producing stage decides how long the operand is unavailable.
  always_comb begin
    mem_match_c = src_match(mem_regwrite, mem_rd);
    wb_match_c  = src_match(wb_regwrite, wb_rd);
    need_c      = NEED_NONE;
    if (ex_match_c) begin
      need_c = NEED_EX;
    end else if (mem_match_c) begin
      need_c = NEED_MEM;
    end else if (wb_match_c) begin
      need_c = NEED_WB;
    end
  end

  // Load/ALU distinction is irrelevant without forwarding.
  always_comb begin
    unused_nofwd = ex_memread;
  end
`endif

  // Next-state logic for the IDLE/STALL/FLUSH sequencer.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (branch_cond) begin
          state_d  = ST_FLUSH;
          remain_d = NEED_NONE;
        end else if (need_c != NEED_NONE) begin
          remain_d = NEED_W'(need_c - NEED_WB);
          if (need_c != NEED_WB) begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (branch_cond) begin
          state_d  = ST_FLUSH;
          remain_d = NEED_NONE;
        end else if (remain_q <= NEED_WB) begin
          state_d  = ST_IDLE;
          remain_d = NEED_NONE;
        end else begin
          remain_d = NEED_W'(remain_q - NEED_WB);
        end
      end
      ST_FLUSH: begin
        remain_d = NEED_NONE;
        state_d  = branch_cond ? ST_FLUSH : ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        remain_d = NEED_NONE;
      end
    endcase
  end

  // Stall/flush outputs; a redirecting branch always wins over a stall.
  always_comb begin
    hazard_c = 1'b0;
    flush_c  = 1'b0;
    if (!reset) begin
      flush_c  = branch_cond || (state_q == ST_FLUSH);
      hazard_c = !branch_cond &&
                 (((state_q == ST_IDLE) && (need_c != NEED_NONE)) ||
                  (state_q == ST_STALL));
    end
  end

  // Consecutive stalled-cycle counter, saturating.
  always_comb begin
    stall_count_d = CNT_W'(0);
    if (hazard_c) begin
      stall_count_d = (stall_count_q == CNT_MAX) ? CNT_MAX
                                                 : CNT_W'(stall_count_q + CNT_W'(1));
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      remain_q      <= NEED_NONE;
      stall_count_q <= CNT_W'(0);
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hazard      = hazard_c;
  assign id_bubble   = hazard_c;
  assign flush       = flush_c;
  assign stall_count = stall_count_q;

  // Fetch hold and squash are mutually exclusive.
  assert property (@(posedge clk) disable iff (reset) !(hazard && flush));

endmodule
